// File: rtl/score_pixel_gen.sv
// score_pixel_gen: two-stage raster classifier for the score display with a 16-slot note table.
// Playhead drawing, cursor control and play events are built only when SCORE_CURSOR_EN is defined.
module score_pixel_gen #(
    parameter int X_LEFT    = 64,
    parameter int SLOT_LOG2 = 5,
    parameter int NOTE_X0   = 12,
    parameter int NOTE_W    = 8,
    parameter int STAFF_TOP = 128,
    parameter int LINE_SP   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        active,
    input  logic        note_we,
    input  logic [3:0]  note_slot,
    input  logic        note_on,
    input  logic [3:0]  note_pitch,
    input  logic [1:0]  note_instr,
    input  logic        beat_tick,
    input  logic        cursor_clear,
    output logic        pixel_valid,
    output logic [1:0]  pixel_type,
    output logic [1:0]  instrument_type,
    output logic [3:0]  cursor_slot,
    output logic        play_valid,
    output logic [3:0]  play_pitch,
    output logic [1:0]  play_instr
);

    typedef struct packed {
        logic       on;
        logic [1:0] instr;
        logic [3:0] pitch;
    } note_t;

    typedef enum logic [1:0] {
        PT_NOTE  = 2'b00,
        PT_STAFF = 2'b01,
        PT_HEAD  = 2'b10,
        PT_BG    = 2'b11
    } pix_t;

    localparam int AREA_W = 16 << SLOT_LOG2;

    note_t tbl_q [16];
    logic [3:0] cur_q;
    note_t      play_q;

    // Note table: a lookup in the same cycle as a write sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (note_we) begin
            tbl_q[note_slot] <= {note_on, note_instr, note_pitch};
        end
    end

`ifdef SCORE_CURSOR_EN
    localparam bit HEAD_EN = 1'b1;

    logic [3:0] cur_d;
    logic       upd_q;

    always_comb begin
        cur_d = cur_q;
        if (cursor_clear) begin
            cur_d = '0;
        end else if (beat_tick) begin
            cur_d = cur_q + 4'd1;
        end
    end

    // The play event looks at the slot the cursor moved to on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q  <= '0;
            upd_q  <= 1'b0;
            play_q <= '0;
        end else begin
            cur_q  <= cur_d;
            upd_q  <= beat_tick | cursor_clear;
            play_q <= (upd_q && tbl_q[cur_q].on) ? tbl_q[cur_q] : '0;
        end
    end
`else
    localparam bit HEAD_EN = 1'b0;

    logic unused_cursor_in;
    assign unused_cursor_in = beat_tick ^ cursor_clear;
    assign cur_q  = '0;
    assign play_q = '0;
`endif

    logic [11:0]          xr;
    logic                 in_area;
    logic [3:0]           slot_s;
    logic                 s1_act_q;
    logic                 s1_area_q;
    logic                 s1_head_q;
    logic [SLOT_LOG2-1:0] s1_off_q;
    logic [9:0]           s1_y_q;
    note_t                s1_ent_q;

    always_comb begin
        xr      = {1'b0, x} - 12'(X_LEFT);
        in_area = ({1'b0, x} >= 12'(X_LEFT)) && (xr < 12'(AREA_W));
        slot_s  = xr[SLOT_LOG2 +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_act_q  <= 1'b0;
            s1_area_q <= 1'b0;
            s1_head_q <= 1'b0;
            s1_off_q  <= '0;
            s1_y_q    <= '0;
            s1_ent_q  <= '0;
        end else begin
            s1_act_q  <= active;
            s1_area_q <= in_area;
            s1_head_q <= in_area && (slot_s == cur_q);
            s1_off_q  <= xr[SLOT_LOG2-1:0];
            s1_y_q    <= y;
            s1_ent_q  <= tbl_q[slot_s];
        end
    end

    int   yi_c;
    int   off_c;
    int   yc_c;
    int   dy_c;
    logic note_hit;
    logic head_hit;
    logic staff_hit;

    // Signed integer arithmetic keeps the note-centre subtraction free of wrap.
    always_comb begin
        yi_c     = int'(s1_y_q);
        off_c    = int'(s1_off_q);
        yc_c     = STAFF_TOP + 4 * LINE_SP - int'(s1_ent_q.pitch) * (LINE_SP / 2);
        dy_c     = yi_c - yc_c;
        note_hit = s1_area_q && s1_ent_q.on
                   && (off_c >= NOTE_X0) && (off_c < NOTE_X0 + NOTE_W)
                   && (dy_c <= LINE_SP / 2 - 1) && (dy_c >= 1 - LINE_SP / 2);
        head_hit = HEAD_EN && s1_head_q && (off_c < 2)
                   && (yi_c >= STAFF_TOP - 4 * LINE_SP) && (yi_c < STAFF_TOP + 5 * LINE_SP);
        staff_hit = 1'b0;
        for (int unsigned k = 0; k < 5; k++) begin
            staff_hit = staff_hit | (s1_area_q && (yi_c == STAFF_TOP + int'(k) * LINE_SP));
        end
    end

    logic       valid_d, valid_q;
    pix_t       type_d, type_q;
    logic [1:0] instr_d, instr_q;

    always_comb begin
        valid_d = s1_act_q;
        type_d  = PT_BG;
        instr_d = '0;
        if (s1_act_q) begin
            if (note_hit) begin
                type_d  = PT_NOTE;
                instr_d = s1_ent_q.instr;
            end else if (head_hit) begin
                type_d = PT_HEAD;
            end else if (staff_hit) begin
                type_d = PT_STAFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            type_q  <= PT_BG;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            type_q  <= type_d;
            instr_q <= instr_d;
        end
    end

    assign pixel_valid     = valid_q;
    assign pixel_type      = type_q;
    assign instrument_type = instr_q;
    assign cursor_slot     = cur_q;
    assign play_valid      = play_q.on;
    assign play_pitch      = play_q.pitch;
    assign play_instr      = play_q.instr;

endmodule
